// File: rtl/alu_unit.sv
// alu_unit: single-cycle ALU with valid/ready issue port and an in-order
// output FIFO that drains to the CDB over a second valid/ready handshake.
//
// Ports:
//   clk_in, rst_in      clock, synchronous active-high reset
//   rdy_in              global enable; low freezes all state
//   clear               flush of all buffered results (needs rdy_in)
//   in_valid/in_ready   issue handshake; in_a, in_b, in_op, in_rs_index,
//                       in_rob_tag carry the operation
//   out_valid/out_ready CDB handshake; out_result, out_rs_index,
//                       out_rob_tag, out_is_branch describe the FIFO head
//   busy                FIFO holds at least one result
//
// Optional feature macro ALU_STATS_EN adds stat_ops (popped entries) and
// stat_full (cycles with in_valid & !in_ready) 32-bit counters.
`timescale 1ns/1ps

module alu_unit #(
  parameter int XLEN       = 32,
  parameter int ROB_WIDTH  = 4,
  parameter int RS_WIDTH   = 2,
  parameter int OBUF_DEPTH = 4
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 clear,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [XLEN-1:0]      in_a,
  input  logic [XLEN-1:0]      in_b,
  input  logic [3:0]           in_op,
  input  logic [RS_WIDTH-1:0]  in_rs_index,
  input  logic [ROB_WIDTH-1:0] in_rob_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XLEN-1:0]      out_result,
  output logic [RS_WIDTH-1:0]  out_rs_index,
  output logic [ROB_WIDTH-1:0] out_rob_tag,
  output logic                 out_is_branch,
  output logic                 busy
`ifdef ALU_STATS_EN
  ,
  output logic [31:0]          stat_ops,
  output logic [31:0]          stat_full
`endif
);

  localparam int PTR_W = $clog2(OBUF_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(OBUF_DEPTH);

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,  OP_SUB  = 4'd1,  OP_AND  = 4'd2,  OP_OR    = 4'd3,
    OP_XOR  = 4'd4,  OP_SLL  = 4'd5,  OP_SRL  = 4'd6,  OP_SRA   = 4'd7,
    OP_SLT  = 4'd8,  OP_SLTU = 4'd9,  OP_BEQ  = 4'd10, OP_BGE   = 4'd11,
    OP_BGEU = 4'd12, OP_BNE  = 4'd13, OP_ADD_PC = 4'd14, OP_RSVD = 4'd15
  } op_e;

  typedef struct packed {
    logic [XLEN-1:0]      result;
    logic [RS_WIDTH-1:0]  rs_index;
    logic [ROB_WIDTH-1:0] rob_tag;
    logic                 is_branch;
  } entry_t;

  // ---------------- combinational ALU ----------------
  logic [XLEN-1:0] alu_result;
  logic            alu_is_branch;
  logic [4:0]      shamt;
  entry_t          alu_entry;

  assign shamt = in_b[4:0];

  always_comb begin
    alu_result    = '0;
    alu_is_branch = 1'b0;
    case (op_e'(in_op))
      OP_ADD:    alu_result = in_a + in_b;
      OP_SUB:    alu_result = in_a - in_b;
      OP_AND:    alu_result = in_a & in_b;
      OP_OR:     alu_result = in_a | in_b;
      OP_XOR:    alu_result = in_a ^ in_b;
      OP_SLL:    alu_result = in_a << shamt;
      OP_SRL:    alu_result = in_a >> shamt;
      OP_SRA:    alu_result = $signed(in_a) >>> shamt;
      OP_SLT:    alu_result = {{(XLEN-1){1'b0}}, $signed(in_a) < $signed(in_b)};
      OP_SLTU:   alu_result = {{(XLEN-1){1'b0}}, in_a < in_b};
      OP_BEQ: begin
        alu_result    = {{(XLEN-1){1'b0}}, in_a == in_b};
        alu_is_branch = 1'b1;
      end
      OP_BGE: begin
        alu_result    = {{(XLEN-1){1'b0}}, $signed(in_a) >= $signed(in_b)};
        alu_is_branch = 1'b1;
      end
      OP_BGEU: begin
        alu_result    = {{(XLEN-1){1'b0}}, in_a >= in_b};
        alu_is_branch = 1'b1;
      end
      OP_BNE: begin
        alu_result    = {{(XLEN-1){1'b0}}, in_a != in_b};
        alu_is_branch = 1'b1;
      end
      OP_ADD_PC: alu_result = in_a + in_b - XLEN'(4);
      default:   alu_result = '0;
    endcase
  end

  always_comb begin
    alu_entry           = '0;
    alu_entry.result    = alu_result;
    alu_entry.rs_index  = in_rs_index;
    alu_entry.rob_tag   = in_rob_tag;
    alu_entry.is_branch = alu_is_branch;
  end

  // ---------------- output FIFO ----------------
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             push, pop;
  entry_t           entry_array [OBUF_DEPTH];
  entry_t           head;

  // in_ready depends only on count, never on out_ready: a full FIFO
  // refuses input even when it is draining in the same cycle.
  assign in_ready = !rst_in && rdy_in && !clear && (count_reg < DEPTH_CNT);
  assign push     = in_valid && in_ready;
  assign pop      = out_valid && out_ready && rdy_in && !clear;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (rdy_in) begin
      if (clear) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
        count_reg  <= '0;
      end else begin
        if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
        if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
        case ({push, pop})
          2'b10:   count_reg <= count_reg + CNT_W'(1);
          2'b01:   count_reg <= count_reg - CNT_W'(1);
          default: count_reg <= count_reg;
        endcase
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < OBUF_DEPTH; gi++) begin : g_entry
      entry_t entry_reg;
      always_ff @(posedge clk_in) begin
        if (rst_in)
          entry_reg <= '0;
        else if (push && (wr_ptr_reg == PTR_W'(gi)))
          entry_reg <= alu_entry;
      end
      assign entry_array[gi] = entry_reg;
    end
  endgenerate

  // Head fields read zero while empty so stale entries never leak out.
  assign out_valid     = (count_reg != '0);
  assign busy          = out_valid;
  assign head          = out_valid ? entry_array[rd_ptr_reg] : '0;
  assign out_result    = head.result;
  assign out_rs_index  = head.rs_index;
  assign out_rob_tag   = head.rob_tag;
  assign out_is_branch = head.is_branch;

`ifdef ALU_STATS_EN
  logic [31:0] stat_ops_reg, stat_full_reg;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      stat_ops_reg  <= '0;
      stat_full_reg <= '0;
    end else if (rdy_in) begin
      if (pop)                   stat_ops_reg  <= stat_ops_reg + 32'd1;
      if (in_valid && !in_ready) stat_full_reg <= stat_full_reg + 32'd1;
    end
  end

  assign stat_ops  = stat_ops_reg;
  assign stat_full = stat_full_reg;
`endif

endmodule

// File: doc/alu_unit.md
# alu_unit

Parametrised, buffered successor to the single-shot ALU. Accepts one operation per cycle from the reservation-station issue port over a valid/ready handshake and computes it in one cycle. Results, tagged with RS index and ROB tag, go into an in-order output FIFO. The FIFO drains to the CDB arbiter over a second valid/ready handshake, so a stalled CDB no longer loses results. Supports flush on `clear`, global stall on `rdy_in`, and a signed/unsigned-correct comparator set.

## Interface
Reset is synchronous and active-high. The block has one clock, `clk_in`; reset is `rst_in`.

Parameters:
- `XLEN`, 32, operand/result width.
- `ROB_WIDTH`, 4, ROB tag width.
- `RS_WIDTH`, 2, RS entry index width.
- `OBUF_DEPTH`, 4, output FIFO entries; power of two, ≥2.

Ports:
- `clk_in` in 1: clock.
- `rst_in` in 1: synchronous active-high reset.
- `rdy_in` in 1: global enable; low freezes all state.
- `clear` in 1: pipeline flush (mispredict); effective only with `rdy_in`.
- `in_valid` in 1: issue request.
- `in_ready` out 1: block can accept this cycle.
- `in_a`, `in_b` in XLEN: operands.
- `in_op` in 4: opcode.
- `in_rs_index` in RS_WIDTH: source RS entry.
- `in_rob_tag` in ROB_WIDTH: destination ROB tag.
- `out_valid` out 1: FIFO head valid.
- `out_ready` in 1: CDB grant.
- `out_result` out XLEN: head result.
- `out_rs_index` out RS_WIDTH: head RS index.
- `out_rob_tag` out ROB_WIDTH: head ROB tag.
- `out_is_branch` out 1: head op was BEQ/BGE/BGEU/BNE.
- `busy` out 1: FIFO non-empty.

## Operation
- Opcodes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR.
  - 5 SLL, 6 SRL, 7 SRA: shift amount is `in_b[4:0]`; SRA is an arithmetic shift of the signed `in_a`.
  - 8 SLT: signed compare. 9 SLTU: unsigned compare.
  - 10 BEQ, 11 BGE (signed), 12 BGEU, 13 BNE.
  - 14 ADD_PC: `a+b-4`, modulo 2^XLEN.
  - 15 reserved: result 0, `out_is_branch` 0.
- Compare and branch ops return 1 or 0, zero-extended.
- Accept condition: `in_valid & in_ready`. The result is computed combinationally and written to the FIFO tail at that edge.
- `in_ready` = `!rst_in & rdy_in & !clear & (count < OBUF_DEPTH)`.
  - There is no combinational path from `out_ready` to `in_ready`.
  - A full FIFO refuses input even if it is popping in the same cycle.
- Pop condition: `out_valid & out_ready & rdy_in`.
- Simultaneous push and pop with count between 1 and DEPTH-1: count is unchanged and both pointers advance.
- Pointers are `log2(OBUF_DEPTH)` bits and wrap modulo the depth. Count is `log2(OBUF_DEPTH)+1` bits.
- `clear & rdy_in`:
  - Pointers and count go to 0 at the edge.
  - Any same-cycle accept or pop is void.
- `rdy_in` low: pointers, count and storage hold. Outputs stay stable and no pop occurs.

## Timing
- Latency: an op accepted at edge N appears on `out_valid` after edge N if the FIFO was empty. Otherwise it waits behind older entries in strict issue order.
- Throughput: 1 op/cycle sustained while `out_ready` is held high.
- `out_*` are driven from FIFO storage; there are no combinational paths from any input to `out_*`.
- Reset values: `out_valid` 0, `busy` 0, `out_result` 0, `out_rs_index` 0, `out_rob_tag` 0, `out_is_branch` 0, `in_ready` 0 while `rst_in` is high. Storage is zeroed.
- Reset asserted mid-stream discards all entries at that edge. `in_ready` rises in the first cycle with `rst_in` low.

## Configuration
- `ALU_STATS_EN` defined:
  - Adds outputs `stat_ops` (32-bit count of popped entries) and `stat_full` (32-bit count of cycles with `in_valid & !in_ready`).
  - Both counters reset to 0 and wrap at 2^32.
  - Both freeze when `rdy_in` is low.
  - Neither counter is cleared by `clear`.
- `ALU_STATS_EN` undefined: the ports and counters are absent. Functional behaviour is identical.

## Test plan
- Arithmetic:
  - ADD a=7, b=5 → 12. SUB 3−5 → 0xFFFFFFFE.
  - SRA 0x80000000 by 4 → 0xF8000000.
  - ADD_PC a=0x100, b=0x20 → 0x11C.
  - `out_valid` rises one cycle after accept.
- Signedness:
  - SLT a=0xFFFFFFFF, b=1 → 1. SLTU on the same operands → 0.
  - BGE a=−1, b=0 → 0 with `out_is_branch`=1. BGEU on the same operands → 1.
- Backpressure:
  - Hold `out_ready`=0 and issue 5 ops with DEPTH=4. `in_ready` drops after the 4th accept.
  - Raise `out_ready`: tags pop in order 0,1,2,3, then the 5th op is accepted.
- Flush: fill 3 entries, then assert `clear` with `rdy_in`=1 and `in_valid`=1 in the same cycle. Next cycle `out_valid`=0 and count is 0; the same-cycle input is dropped.
- Stall: with 2 entries and `out_ready`=1, drop `rdy_in` for 3 cycles. Head outputs stay constant and no pops occur; draining resumes once `rdy_in` returns.
- Reset mid-stream: assert `rst_in` with 2 entries. After the edge all outputs are 0. With `ALU_STATS_EN` defined, `stat_ops`=0.
